// File: rtl/shiftreg_pkg.sv
// Shared definitions for the serial shift-register controllers (read and write side).
// Contents:
//   shiftreg_state_t  - controller state encoding (IDLE, SHIFT_LO, SHIFT_HI, LATCH)
//   SHIFTREG_WIDTH    - default bits per chain transfer
//   SHIFTREG_CLK_DIV  - default system cycles per serial-clock half-period
//   cnt_width()       - width of a counter that must hold 0..n-1, at least 1 bit
package shiftreg_pkg;

  localparam int SHIFTREG_WIDTH   = 16;
  localparam int SHIFTREG_CLK_DIV = 2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2,
    LATCH    = 2'd3
  } shiftreg_state_t;

  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/shiftreg_out_ctl_if.sv
// Parallel-word handshake into the serial-out shift-register driver.
// Signals:
//   data_in    - word to transmit, bit WIDTH-1 leaves first
//   data_valid - producer requests a transfer
//   ready      - driver is idle and accepts a word this cycle
// Modports: master (producer side), slave (driver side).
interface shiftreg_out_ctl_if
  import shiftreg_pkg::*;
#(
  parameter int WIDTH = SHIFTREG_WIDTH
);
  logic [WIDTH-1:0] data_in;
  logic             data_valid;
  logic             ready;

  modport master (output data_in, output data_valid, input ready);
  modport slave  (input data_in, input data_valid, output ready);
endinterface

// File: rtl/shiftreg_tick_gen.sv
// Phase timer for the serial clock: counts CLK_DIV system cycles per phase and
// strobes on the last cycle of each phase.
// Ports:
//   clk   - system clock
//   reset - synchronous active-high reset
//   clear - holds the counter at 0 (used while the controller is idle)
//   tick  - single-cycle phase-end strobe
module shiftreg_tick_gen
  import shiftreg_pkg::*;
#(
  parameter int CLK_DIV = SHIFTREG_CLK_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);
  localparam int CW = cnt_width(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // With CLK_DIV=1 the counter sits at 0 and every busy cycle ends a phase.
  assign tick = (r_cnt == LAST) && !clear;

endmodule

// File: rtl/shiftreg_out_ctl.sv
// Serial-out driver for a 74HC595-style SIPO chain. Accepts a word over a
// valid/ready handshake, shifts it MSB-first on a divided serial clock, then
// pulses the storage latch. All chain-facing outputs are registered.
// Ports:
//   clk            - system clock, rising edge
//   reset          - synchronous active-high reset
//   bus            - slave handshake (data_in, data_valid, ready)
//   shiftreg_clk   - SRCLK to the chain
//   shiftreg_data  - SER to the chain
//   shiftreg_latch - RCLK pulse, active high
//   shiftreg_oe_n  - chain output enable, active low; stays high until the first latch
module shiftreg_out_ctl
  import shiftreg_pkg::*;
#(
  parameter int WIDTH   = SHIFTREG_WIDTH,
  parameter int CLK_DIV = SHIFTREG_CLK_DIV
) (
  input  logic               clk,
  input  logic               reset,
  shiftreg_out_ctl_if.slave  bus,
  output logic               shiftreg_clk,
  output logic               shiftreg_data,
  output logic               shiftreg_latch,
  output logic               shiftreg_oe_n
);
  localparam int IW = cnt_width(WIDTH);
  localparam logic [IW-1:0] IDX_TOP = IW'(WIDTH - 1);

  shiftreg_state_t r_state, w_state_next;
  logic [WIDTH-1:0] r_word, w_word_next;
  logic [IW-1:0]    r_idx, w_idx_next, w_idx_dec;
  logic r_ready, w_ready_next;
  logic r_sclk, w_sclk_next;
  logic r_sdata, w_sdata_next;
  logic r_latch, w_latch_next;
  logic r_oe_n, w_oe_n_next;
  logic w_tick;

  shiftreg_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .clear (r_state == IDLE),
    .tick  (w_tick)
  );

  assign w_idx_dec = r_idx - 1'b1;

  // Next-state logic also produces the next value of every output, so the
  // pins come straight from flops and cannot glitch on state decode.
  always_comb begin
    w_state_next = r_state;
    w_word_next  = r_word;
    w_idx_next   = r_idx;
    w_ready_next = r_ready;
    w_sclk_next  = r_sclk;
    w_sdata_next = r_sdata;
    w_latch_next = r_latch;
    w_oe_n_next  = r_oe_n;
    unique case (r_state)
      IDLE: begin
        if (bus.data_valid) begin
          w_state_next = SHIFT_LO;
          w_word_next  = bus.data_in;
          w_idx_next   = IDX_TOP;
          w_sdata_next = bus.data_in[WIDTH-1];
          w_ready_next = 1'b0;
          w_sclk_next  = 1'b0;
        end
      end
      SHIFT_LO: begin
        if (w_tick) begin
          w_state_next = SHIFT_HI;
          w_sclk_next  = 1'b1;
        end
      end
      SHIFT_HI: begin
        if (w_tick) begin
          w_sclk_next = 1'b0;
          if (r_idx == '0) begin
            w_state_next = LATCH;
            w_latch_next = 1'b1;
          end else begin
            // Data only changes at SHIFT_LO entry, giving a full phase of setup.
            w_state_next = SHIFT_LO;
            w_idx_next   = w_idx_dec;
            w_sdata_next = r_word[w_idx_dec];
          end
        end
      end
      LATCH: begin
        if (w_tick) begin
          w_state_next = IDLE;
          w_latch_next = 1'b0;
          w_ready_next = 1'b1;
          w_oe_n_next  = 1'b0;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_word  <= '0;
      r_idx   <= '0;
      r_ready <= 1'b1;
      r_sclk  <= 1'b0;
      r_sdata <= 1'b0;
      r_latch <= 1'b0;
      r_oe_n  <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_word  <= w_word_next;
      r_idx   <= w_idx_next;
      r_ready <= w_ready_next;
      r_sclk  <= w_sclk_next;
      r_sdata <= w_sdata_next;
      r_latch <= w_latch_next;
      r_oe_n  <= w_oe_n_next;
    end
  end

  assign bus.ready      = r_ready;
  assign shiftreg_clk   = r_sclk;
  assign shiftreg_data  = r_sdata;
  assign shiftreg_latch = r_latch;
  assign shiftreg_oe_n  = r_oe_n;

endmodule

// File: tb/tb_shiftreg_out_ctl.sv
module tb_shiftreg_out_ctl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  shiftreg_out_ctl_if #(.WIDTH(16)) bus16 ();
  shiftreg_out_ctl_if #(.WIDTH(8))  bus8 ();

  logic sclk16, sdata16, latch16, oe16;
  logic sclk8, sdata8, latch8, oe8;

  shiftreg_out_ctl #(.WIDTH(16), .CLK_DIV(2)) dut16 (
    .clk(clk), .reset(reset), .bus(bus16),
    .shiftreg_clk(sclk16), .shiftreg_data(sdata16),
    .shiftreg_latch(latch16), .shiftreg_oe_n(oe16)
  );

  shiftreg_out_ctl #(.WIDTH(8), .CLK_DIV(1)) dut8 (
    .clk(clk), .reset(reset), .bus(bus8),
    .shiftreg_clk(sclk8), .shiftreg_data(sdata8),
    .shiftreg_latch(latch8), .shiftreg_oe_n(oe8)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Chain-side monitors: record the data bit at each SRCLK rising edge and count latch pulses.
  logic [31:0] bits16 = '0, bits8 = '0;
  int rises16 = 0, latches16 = 0, lcyc16 = 0;
  int rises8 = 0, latches8 = 0;
  logic prev_sclk16 = 1'b0, prev_latch16 = 1'b0;
  logic prev_sclk8 = 1'b0, prev_latch8 = 1'b0;

  always @(negedge clk) begin
    if (sclk16 && !prev_sclk16) begin
      rises16 <= rises16 + 1;
      bits16  <= {bits16[30:0], sdata16};
    end
    if (latch16 && !prev_latch16) latches16 <= latches16 + 1;
    if (latch16) lcyc16 <= lcyc16 + 1;
    prev_sclk16  <= sclk16;
    prev_latch16 <= latch16;
    if (sclk8 && !prev_sclk8) begin
      rises8 <= rises8 + 1;
      bits8  <= {bits8[30:0], sdata8};
    end
    if (latch8 && !prev_latch8) latches8 <= latches8 + 1;
    prev_sclk8  <= sclk8;
    prev_latch8 <= latch8;
  end

  // Sends one word on the 16-bit DUT; optionally pulses data_valid=1 with 0xFFFF
  // at busy cycle pulse_at. Returns the number of sampled cycles ready was low.
  task automatic send16(input logic [15:0] w, input int pulse_at,
                        input logic exp_oe_mid, input string tag, output int busy);
    @(negedge clk);
    bus16.data_in = w;
    bus16.data_valid = 1'b1;
    @(negedge clk);
    bus16.data_valid = 1'b0;
    bus16.data_in = 16'h0;
    busy = 0;
    while (!bus16.ready && busy < 1000) begin
      busy++;
      if (busy == 5) check_eq({tag, "_oe_mid"}, 32'(oe16), 32'(exp_oe_mid));
      if (busy == pulse_at) begin
        bus16.data_valid = 1'b1;
        bus16.data_in = 16'hFFFF;
      end else begin
        bus16.data_valid = 1'b0;
        bus16.data_in = 16'h0;
      end
      @(negedge clk);
    end
    bus16.data_valid = 1'b0;
    if (busy >= 1000) check_eq({tag, "_timeout"}, 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_ready16(output int busy);
    busy = 0;
    while (busy < 1000) begin
      @(negedge clk);
      if (bus16.ready) break;
      busy++;
    end
    if (busy >= 1000) check_eq("wait_timeout", 32'(busy), 32'd0);
  endtask

  initial begin
    int busy, busy2, r0, l0, c0, toggles;
    logic prev;
    bus16.data_in = '0; bus16.data_valid = 1'b0;
    bus8.data_in  = '0; bus8.data_valid  = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state, and no serial activity while idle.
    check_eq("rst_ready", 32'(bus16.ready), 32'd1);
    check_eq("rst_oe_n", 32'(oe16), 32'd1);
    check_eq("rst_sclk", 32'(sclk16), 32'd0);
    check_eq("rst_latch", 32'(latch16), 32'd0);
    check_eq("rst_data", 32'(sdata16), 32'd0);
    repeat (6) @(negedge clk);
    check_eq("idle_rises", 32'(rises16), 32'd0);
    $display("txn reset: ready=%0d oe_n=%0d", bus16.ready, oe16);

    // 0xA5C3 with defaults.
    r0 = rises16; l0 = latches16; c0 = lcyc16;
    send16(16'hA5C3, 0, 1'b1, "a5c3", busy);
    check_eq("a5c3_busy", 32'(busy), 32'd66);
    check_eq("a5c3_bits", {16'h0, bits16[15:0]}, 32'h0000A5C3);
    check_eq("a5c3_rises", 32'(rises16 - r0), 32'd16);
    check_eq("a5c3_latches", 32'(latches16 - l0), 32'd1);
    check_eq("a5c3_latch_len", 32'(lcyc16 - c0), 32'd2);
    check_eq("a5c3_oe_after", 32'(oe16), 32'd0);
    $display("txn a5c3: busy=%0d bits=0x%04h", busy, bits16[15:0]);

    // Back-to-back 0xFFFF then 0x0001 with data_valid held high.
    r0 = rises16; l0 = latches16;
    @(negedge clk);
    bus16.data_in = 16'hFFFF;
    bus16.data_valid = 1'b1;
    @(posedge clk); #1;
    bus16.data_in = 16'h0001;
    wait_ready16(busy);
    check_eq("b2b_busy1", 32'(busy), 32'd66);
    @(negedge clk);
    check_eq("b2b_restart", 32'(bus16.ready), 32'd0);
    bus16.data_valid = 1'b0;
    wait_ready16(busy2);
    check_eq("b2b_busy2", 32'(busy2), 32'd65);
    repeat (2) @(negedge clk);
    check_eq("b2b_bits", bits16, 32'hFFFF0001);
    check_eq("b2b_rises", 32'(rises16 - r0), 32'd32);
    check_eq("b2b_latches", 32'(latches16 - l0), 32'd2);
    check_eq("b2b_oe", 32'(oe16), 32'd0);
    $display("txn b2b: busy=%0d/%0d bits=0x%08h", busy, busy2, bits16);

    // 0x1234 with a stray data_valid pulse at busy cycle 10.
    r0 = rises16; l0 = latches16;
    send16(16'h1234, 10, 1'b0, "ign", busy);
    check_eq("ign_busy", 32'(busy), 32'd66);
    check_eq("ign_bits", {16'h0, bits16[15:0]}, 32'h00001234);
    check_eq("ign_rises", 32'(rises16 - r0), 32'd16);
    check_eq("ign_latches", 32'(latches16 - l0), 32'd1);
    @(negedge clk);
    check_eq("ign_idle_ready", 32'(bus16.ready), 32'd1);
    $display("txn ignore: busy=%0d bits=0x%04h", busy, bits16[15:0]);

    // Reset asserted at busy cycle 20 aborts without a latch pulse.
    l0 = latches16;
    @(negedge clk);
    bus16.data_in = 16'hA5C3;
    bus16.data_valid = 1'b1;
    @(negedge clk);
    bus16.data_valid = 1'b0;
    repeat (19) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check_eq("abort_ready", 32'(bus16.ready), 32'd1);
    check_eq("abort_sclk", 32'(sclk16), 32'd0);
    check_eq("abort_data", 32'(sdata16), 32'd0);
    check_eq("abort_latch", 32'(latch16), 32'd0);
    check_eq("abort_oe_n", 32'(oe16), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("abort_no_latch", 32'(latches16 - l0), 32'd0);
    $display("txn abort: ready=%0d oe_n=%0d", bus16.ready, oe16);

    r0 = rises16; l0 = latches16;
    send16(16'h00FF, 0, 1'b1, "post", busy);
    check_eq("post_busy", 32'(busy), 32'd66);
    check_eq("post_bits", {16'h0, bits16[15:0]}, 32'h000000FF);
    check_eq("post_rises", 32'(rises16 - r0), 32'd16);
    check_eq("post_latches", 32'(latches16 - l0), 32'd1);
    check_eq("post_oe", 32'(oe16), 32'd0);
    $display("txn post_abort: busy=%0d bits=0x%04h", busy, bits16[15:0]);

    // WIDTH=8, CLK_DIV=1: 0x81.
    r0 = rises8; l0 = latches8;
    @(negedge clk);
    bus8.data_in = 8'h81;
    bus8.data_valid = 1'b1;
    @(negedge clk);
    bus8.data_valid = 1'b0;
    busy = 0; toggles = 0; prev = sclk8;
    while (!bus8.ready && busy < 1000) begin
      busy++;
      if (busy > 1 && sclk8 != prev) toggles++;
      prev = sclk8;
      @(negedge clk);
    end
    if (busy >= 1000) check_eq("w8_timeout", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    check_eq("w8_busy", 32'(busy), 32'd17);
    check_eq("w8_toggles", 32'(toggles), 32'd16);
    check_eq("w8_bits", {24'h0, bits8[7:0]}, 32'h00000081);
    check_eq("w8_rises", 32'(rises8 - r0), 32'd8);
    check_eq("w8_latches", 32'(latches8 - l0), 32'd1);
    check_eq("w8_oe", 32'(oe8), 32'd0);
    $display("txn w8: busy=%0d toggles=%0d bits=0x%02h", busy, toggles, bits8[7:0]);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
